// File: rtl/pong_game.sv
// pong_game: two-player Pong on a 16x16 cell grid.
// Game state advances only on the one-cycle tick pulse. The ball waits at
// centre for SERVE_TICKS ticks, then moves one cell every SPEED_DIV ticks.
// It bounces off the top and bottom walls and off the paddles. A miss scores
// for the opponent, freezes the ball for one tick, and then re-serves toward
// the scorer.
// Optional build macro PONG_AUTOPLAY_EN: the right paddle tracks the ball on
// its own and ignores rup/rdown.
module pong_game #(
  parameter int PADDLE_LEN  = 3,
  parameter int SPEED_DIV   = 4,
  parameter int SERVE_TICKS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        lup,
  input  logic        ldown,
  input  logic        rup,
  input  logic        rdown,
  output logic [3:0]  ball_x,
  output logic [3:0]  ball_y,
  output logic [15:0] lpaddle,
  output logic [15:0] rpaddle,
  output logic [3:0]  lscore,
  output logic [3:0]  rscore,
  output logic        serving
);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORED} state_t;

  localparam logic [3:0]  POS_MAX  = 4'(16 - PADDLE_LEN);
  localparam logic [3:0]  POS_RST  = 4'((16 - PADDLE_LEN) / 2);
  localparam logic [15:0] PAD_ONES = 16'((1 << PADDLE_LEN) - 1);
  localparam logic [3:0]  CENTRE   = 4'd7;

  state_t      state_q, state_d;
  logic [7:0]  serve_cnt_q, serve_cnt_d;
  logic [3:0]  step_cnt_q, step_cnt_d;
  logic [3:0]  ball_x_q, ball_x_d;
  logic [3:0]  ball_y_q, ball_y_d;
  logic        dx_q, dx_d;          // 1 = moving right
  logic        dy_q, dy_d;          // 1 = moving down
  logic [3:0]  lpos_q, lpos_d;
  logic [3:0]  rpos_q, rpos_d;
  logic [3:0]  lscore_q, lscore_d;
  logic [3:0]  rscore_q, rscore_d;
  logic        r_up, r_dn;

  // Button-driven paddle motion: exactly one button moves, within the grid.
  function automatic logic [3:0] paddle_next(input logic [3:0] pos,
                                             input logic up, input logic dn);
    logic [3:0] nxt;
    nxt = pos;
    if (up && !dn && (pos != 4'd0))
      nxt = pos - 4'd1;
    else if (dn && !up && (pos < POS_MAX))
      nxt = pos + 4'd1;
    return nxt;
  endfunction

  // Paddle masks are a pure function of the registered top row.
  assign lpaddle = PAD_ONES << lpos_q;
  assign rpaddle = PAD_ONES << rpos_q;
  assign ball_x  = ball_x_q;
  assign ball_y  = ball_y_q;
  assign lscore  = lscore_q;
  assign rscore  = rscore_q;
  assign serving = (state_q == S_SERVE);

`ifdef PONG_AUTOPLAY_EN
  // Right paddle chases the ball row; the buttons are unused in this build.
  always_comb begin
    r_up = ({1'b0, ball_y_q} < {1'b0, rpos_q});
    r_dn = ({1'b0, ball_y_q} > ({1'b0, rpos_q} + 5'(PADDLE_LEN - 1)));
  end
  logic unused_rbtn;
  assign unused_rbtn = rup ^ rdown;
`else
  // Right paddle follows its buttons.
  always_comb begin
    r_up = rup;
    r_dn = rdown;
  end
`endif

  // Next-state logic: everything holds unless tick is high.
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    step_cnt_d  = step_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    lpos_d      = lpos_q;
    rpos_d      = rpos_q;
    lscore_d    = lscore_q;
    rscore_d    = rscore_q;
    if (tick) begin
      lpos_d = paddle_next(lpos_q, lup, ldown);
      rpos_d = paddle_next(rpos_q, r_up, r_dn);
      case (state_q)
        S_SERVE: begin
          serve_cnt_d = serve_cnt_q + 8'd1;
          if (serve_cnt_d == 8'(SERVE_TICKS)) begin
            state_d    = S_PLAY;
            step_cnt_d = 4'd0;
          end
        end
        S_PLAY: begin
          step_cnt_d = step_cnt_q + 4'd1;
          if (step_cnt_d == 4'(SPEED_DIV)) begin
            step_cnt_d = 4'd0;
            // Vertical: reflect off the top and bottom walls.
            if (dy_q && (ball_y_q == 4'd15)) begin
              dy_d     = 1'b0;
              ball_y_d = 4'd14;
            end else if (!dy_q && (ball_y_q == 4'd0)) begin
              dy_d     = 1'b1;
              ball_y_d = 4'd1;
            end else begin
              ball_y_d = dy_q ? ball_y_q + 4'd1 : ball_y_q - 4'd1;
            end
            // Horizontal: columns 1 and 14 are the paddle faces, and the
            // hit test uses the pre-step row and pre-move mask.
            if (!dx_q && (ball_x_q == 4'd1)) begin
              if (lpaddle[ball_y_q]) begin
                dx_d     = 1'b1;
                ball_x_d = 4'd2;
              end else begin
                ball_x_d = 4'd0;
                rscore_d = rscore_q + 4'd1;
                state_d  = S_SCORED;
              end
            end else if (dx_q && (ball_x_q == 4'd14)) begin
              if (rpaddle[ball_y_q]) begin
                dx_d     = 1'b0;
                ball_x_d = 4'd13;
              end else begin
                ball_x_d = 4'd15;
                lscore_d = lscore_q + 4'd1;
                state_d  = S_SCORED;
              end
            end else begin
              ball_x_d = dx_q ? ball_x_q + 4'd1 : ball_x_q - 4'd1;
            end
          end
        end
        S_SCORED: begin
          // Serve toward the scorer: a ball in column 0 means right scored.
          state_d     = S_SERVE;
          serve_cnt_d = 8'd0;
          ball_x_d    = CENTRE;
          ball_y_d    = CENTRE;
          dx_d        = (ball_x_q == 4'd0);
        end
        default: state_d = S_SERVE;
      endcase
    end
  end

  // State register with synchronous reset that overrides a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SERVE;
      serve_cnt_q <= 8'd0;
      step_cnt_q  <= 4'd0;
      ball_x_q    <= CENTRE;
      ball_y_q    <= CENTRE;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      lpos_q      <= POS_RST;
      rpos_q      <= POS_RST;
      lscore_q    <= 4'd0;
      rscore_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      step_cnt_q  <= step_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      lpos_q      <= lpos_d;
      rpos_q      <= rpos_d;
      lscore_q    <= lscore_d;
      rscore_q    <= rscore_d;
    end
  end

endmodule
